// File: rtl/matrix_ls_sequencer.sv
// Matrix load/store row sequencer: one row request per cycle while mhit returns, done pulse ROWS+1 cycles after accept.
// Accepts only in IDLE (req_ready), each row held until mhit; optional runtime stride under MLS_STRIDE_EN.
package matrix_ls_pkg;
  typedef enum logic [1:0] {
    M_NONE  = 2'd0,
    M_LOAD  = 2'd1,
    M_STORE = 2'd2,
    M_RSVD  = 2'd3
  } matrix_mem_t;
endpackage

module matrix_ls_sequencer
  import matrix_ls_pkg::*;
#(
  parameter int          ROWS       = 4,
  parameter logic [31:0] ROW_STRIDE = 32'd8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    req_valid,
  input  matrix_mem_t             req_opcode,
  input  logic [3:0]              req_rd,
  input  logic [31:0]             req_addr,
`ifdef MLS_STRIDE_EN
  input  logic [31:0]             stride_in,
`endif
  output logic                    req_ready,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [3:0]              mem_rd,
  output logic [$clog2(ROWS)-1:0] mem_row,
  input  logic                    mhit,
  output logic                    busy,
  output logic                    done
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic            is_load_q;
  logic [3:0]      rd_q;
  logic [31:0]     addr_q;
  logic [RW-1:0]   row_q;
  logic [31:0]     stride;

`ifdef MLS_STRIDE_EN
  logic [31:0] stride_q;
  assign stride = stride_q;
`else
  assign stride = ROW_STRIDE;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // addr_q accumulates the stride per completed row, so wrap-around is free
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_load_q <= 1'b0;
      rd_q      <= '0;
      addr_q    <= '0;
      row_q     <= '0;
`ifdef MLS_STRIDE_EN
      stride_q  <= '0;
`endif
    end else if (accept) begin
      is_load_q <= (req_opcode == M_LOAD);
      rd_q      <= req_rd;
      addr_q    <= req_addr;
      row_q     <= '0;
`ifdef MLS_STRIDE_EN
      stride_q  <= stride_in;
`endif
    end else if (state_q == REQ && mhit && row_q != LAST_ROW) begin
      row_q  <= row_q + RW'(1);
      addr_q <= addr_q + stride;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_rd    = '0;
    mem_row   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && (req_opcode == M_LOAD || req_opcode == M_STORE)) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        busy     = 1'b1;
        mem_ren  = is_load_q;
        mem_wen  = !is_load_q;
        mem_addr = addr_q;
        mem_rd   = rd_q;
        mem_row  = row_q;
        if (mhit && row_q == LAST_ROW) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
